// File: rtl/bmu_search_pkg.sv
// Shared types and constants for the GAM winner-search stage.
package bmu_search_pkg;

  localparam int unsigned MAX_NODES = 64;
  localparam int unsigned NODE_ID_W = 6;
  localparam int unsigned CNT_W     = NODE_ID_W + 1;
  localparam int unsigned VEC_DIM   = 4;
  localparam int unsigned ELEM_W    = 16;
  localparam int unsigned ED_W      = 32;

  localparam logic [ED_W-1:0] ED_MAX = 32'hFFFF_FFFF;

  typedef logic [NODE_ID_W-1:0] node_id_T;
  typedef logic [VEC_DIM-1:0][ELEM_W-1:0] node_vector_T;

  typedef struct packed {
    logic            valid;
    node_id_T        id;
    logic [ED_W-1:0] ed;
  } bmu_result_T;

  localparam bmu_result_T RESULT_RST = '{valid: 1'b0, id: '0, ed: ED_MAX};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } bmu_state_T;

  // Limit the requested scan length to the physical node memory size.
  function automatic logic [CNT_W-1:0] clamp_nodes(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_NODES)) ? CNT_W'(MAX_NODES) : n;
  endfunction

endpackage

// File: rtl/bmu_search_min2_tracker.sv
// Keeps the best and second-best (id, ED) pairs seen during a scan.
module min2_tracker
  import bmu_search_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            valid_i,
  input  logic            active_i,
  input  node_id_T        id_i,
  input  logic [ED_W-1:0] ed_i,
  output bmu_result_T     winner_o,
  output bmu_result_T     second_o
);

  bmu_result_T win_q;
  bmu_result_T sec_q;
  bmu_result_T node_c;

  assign node_c = '{valid: 1'b1, id: id_i, ed: ed_i};

  // Strict compares: on equal EDs the earlier (lower) index keeps its place.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      win_q <= RESULT_RST;
      sec_q <= RESULT_RST;
    end else if (valid_i && active_i) begin
      if (ed_i < win_q.ed) begin
        sec_q <= win_q;
        win_q <= node_c;
      end else if (!sec_q.valid || (ed_i < sec_q.ed)) begin
        sec_q <= node_c;
      end
    end
  end

  assign winner_o = win_q;
  assign second_o = sec_q;

endmodule

// File: rtl/bmu_search.sv
// Sequential BMU search: streams node weights to ED_calculator and ranks the returned EDs.
module bmu_search
  import bmu_search_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  node_vector_T     x_in,
  input  logic [CNT_W-1:0] num_nodes,
  output logic             busy,
  output logic             mem_rd_en,
  output node_id_T         mem_rd_addr,
  input  node_vector_T     mem_rd_data,
  input  logic             mem_rd_active,
  output node_vector_T     x_out,
  output node_vector_T     w_out,
  input  logic [ED_W-1:0]  ed_in,
  output logic             done,
  output logic             winner_valid,
  output node_id_T         winner_id,
  output logic [ED_W-1:0]  winner_ed,
  output logic             second_valid,
  output node_id_T         second_id,
  output logic [ED_W-1:0]  second_ed
);

  bmu_state_T       state_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_en_q;
  node_id_T         rd_addr_q;
  node_id_T         last_addr_q;
  logic             drain_q;
  node_vector_T     x_q;
  node_vector_T     w_q;
  logic             pend_q;
  node_id_T         pend_id_q;
  logic             b_valid_q;
  logic             b_active_q;
  node_id_T         b_id_q;

  logic             start_acc_c;
  logic [CNT_W-1:0] n_clamp_c;
  bmu_result_T      winner_c;
  bmu_result_T      second_c;

  assign start_acc_c = (state_q == S_IDLE) && start;
  assign n_clamp_c   = clamp_nodes(num_nodes);

  // Control FSM plus the read pipeline: address -> memory data -> w_out -> compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      drain_q     <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      pend_q      <= 1'b0;
      pend_id_q   <= '0;
      b_valid_q   <= 1'b0;
      b_active_q  <= 1'b0;
      b_id_q      <= '0;
    end else begin
      pend_q     <= rd_en_q;
      pend_id_q  <= rd_addr_q;
      b_valid_q  <= pend_q;
      b_active_q <= mem_rd_active;
      b_id_q     <= pend_id_q;
      if (pend_q) begin
        w_q <= mem_rd_data;
      end
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q <= x_in;
            if (n_clamp_c == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              busy_q      <= 1'b1;
              rd_en_q     <= 1'b1;
              rd_addr_q   <= '0;
              last_addr_q <= NODE_ID_W'(n_clamp_c - CNT_W'(1));
            end
          end
        end
        S_FETCH: begin
          if (rd_addr_q == last_addr_q) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + NODE_ID_W'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles let the last node reach the compare stage.
          if (drain_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  min2_tracker u_min2 (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_acc_c),
    .valid_i  (b_valid_q),
    .active_i (b_active_q),
    .id_i     (b_id_q),
    .ed_i     (ed_in),
    .winner_o (winner_c),
    .second_o (second_c)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = rd_addr_q;
  assign x_out        = x_q;
  assign w_out        = w_q;
  assign winner_valid = winner_c.valid;
  assign winner_id    = winner_c.id;
  assign winner_ed    = winner_c.ed;
  assign second_valid = second_c.valid;
  assign second_id    = second_c.id;
  assign second_ed    = second_c.ed;

endmodule

// File: tb/tb_bmu_search.sv
// Scoreboard bench for bmu_search with a node memory model and an L1 ED model.
module tb_bmu_search;
  import bmu_search_pkg::*;

  logic             clk;
  logic             rst;
  logic             start;
  node_vector_T     x_in;
  logic [CNT_W-1:0] num_nodes;
  logic             busy;
  logic             mem_rd_en;
  node_id_T         mem_rd_addr;
  node_vector_T     mem_rd_data;
  logic             mem_rd_active;
  node_vector_T     x_out;
  node_vector_T     w_out;
  logic [31:0]      ed_in;
  logic             done;
  logic             winner_valid;
  node_id_T         winner_id;
  logic [31:0]      winner_ed;
  logic             second_valid;
  node_id_T         second_id;
  logic [31:0]      second_ed;

  bmu_search dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .x_in          (x_in),
    .num_nodes     (num_nodes),
    .busy          (busy),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_active (mem_rd_active),
    .x_out         (x_out),
    .w_out         (w_out),
    .ed_in         (ed_in),
    .done          (done),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id),
    .winner_ed     (winner_ed),
    .second_valid  (second_valid),
    .second_id     (second_id),
    .second_ed     (second_ed)
  );

  typedef struct {
    int unsigned  edge_exp;
    int unsigned  reads;
    logic         wv;
    logic [5:0]   wid;
    logic [31:0]  wed;
    logic         sv;
    logic [5:0]   sid;
    logic [31:0]  sed;
    node_vector_T x;
  } exp_t;

  exp_t         q[$];
  int           checks;
  int           errors;
  int unsigned  edge_cnt;
  int unsigned  rd_cnt;
  node_vector_T x_cur;
  node_vector_T mem_w [MAX_NODES];
  logic         mem_act [MAX_NODES];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Node memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data   <= mem_w[mem_rd_addr];
      mem_rd_active <= mem_act[mem_rd_addr];
    end
  end

  function automatic logic [31:0] l1_dist(input node_vector_T a, input node_vector_T b);
    logic [31:0] s;
    s = 32'd0;
    for (int d = 0; d < VEC_DIM; d++) begin
      if (a[d] > b[d]) s = s + 32'(a[d] - b[d]);
      else             s = s + 32'(b[d] - a[d]);
    end
    return s;
  endfunction

  always_comb ed_in = l1_dist(x_out, w_out);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic wv, input int wid, input logic [31:0] wed,
                              input logic sv, input int sid, input logic [31:0] sed,
                              input int unsigned reads);
    exp_t e;
    e.edge_exp = 0;
    e.reads    = reads;
    e.wv = wv; e.wid = 6'(wid); e.wed = wed;
    e.sv = sv; e.sid = 6'(sid); e.sed = sed;
    e.x  = '0;
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MAX_NODES; i++) begin
      mem_w[i]   = x_cur;
      mem_w[i][0] = x_cur[0] + 16'd900;
      mem_act[i] = 1'b0;
    end
  endtask

  task automatic load_node(input int i, input logic act, input int unsigned ed);
    mem_w[i]    = x_cur;
    mem_w[i][0] = x_cur[0] + 16'(ed);
    mem_act[i]  = act;
  endtask

  task automatic setup_t1();
    x_cur = {16'd40, 16'd300, 16'd7, 16'd1000};
    clear_mem();
    load_node(0, 1'b1, 50);
    load_node(1, 1'b1, 20);
    load_node(2, 1'b1, 30);
    load_node(3, 1'b1, 10);
  endtask

  task automatic start_scan(input logic [CNT_W-1:0] n, input bit push, input exp_t e_in,
                            output exp_t e_out);
    int unsigned nc;
    @(negedge clk);
    x_in = x_cur; num_nodes = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nc = (n > CNT_W'(MAX_NODES)) ? MAX_NODES : int'(n);
    e_out = e_in;
    e_out.edge_exp = edge_cnt + ((nc == 0) ? 1 : nc + 3) - 1;
    e_out.x = x_cur;
    if (push) q.push_back(e_out);
  endtask

  task automatic wait_done(input string tag, input exp_t e);
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk({tag, "_done_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
    chk({tag, "_hold_wid"}, 64'(winner_id), 64'(e.wid));
    chk({tag, "_hold_wed"}, 64'(winner_ed), 64'(e.wed));
    chk({tag, "_hold_sed"}, 64'(second_ed), 64'(e.sed));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_wv"}, 64'(winner_valid), 64'd0);
    chk({tag, "_sv"}, 64'(second_valid), 64'd0);
    chk({tag, "_wid"}, 64'(winner_id), 64'd0);
    chk({tag, "_sid"}, 64'(second_id), 64'd0);
    chk({tag, "_wed"}, 64'(winner_ed), 64'hFFFF_FFFF);
    chk({tag, "_sed"}, 64'(second_ed), 64'hFFFF_FFFF);
    chk({tag, "_x_out"}, 64'(x_out), 64'd0);
    chk({tag, "_w_out"}, 64'(w_out), 64'd0);
  endtask

  // Monitor: sequential read addresses, and full result check on every done pulse.
  initial begin
    exp_t e;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        chk("rd_addr", 64'(mem_rd_addr), 64'(rd_cnt));
        rd_cnt++;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 64'(edge_cnt), 64'(e.edge_exp));
          chk("read_count", 64'(rd_cnt), 64'(e.reads));
          chk("busy_in_done", 64'(busy), 64'd0);
          chk("x_out", 64'(x_out), 64'(e.x));
          chk("winner_valid", 64'(winner_valid), 64'(e.wv));
          chk("winner_id", 64'(winner_id), 64'(e.wid));
          chk("winner_ed", 64'(winner_ed), 64'(e.wed));
          chk("second_valid", 64'(second_valid), 64'(e.sv));
          chk("second_id", 64'(second_id), 64'(e.sid));
          chk("second_ed", 64'(second_ed), 64'(e.sed));
        end
        rd_cnt = 0;
      end else if (!busy && !mem_rd_en) begin
        rd_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; num_nodes = '0; x_in = '0;
    x_cur = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Distinct EDs: winner and runner-up both change during the scan.
    setup_t1();
    start_scan(7'd4, 1'b1, mk(1'b1, 3, 10, 1'b1, 1, 20, 4), e);
    wait_done("t1", e);

    // Equal EDs: lower index keeps both places.
    x_cur = {16'd1, 16'd2, 16'd3, 16'd500};
    clear_mem();
    load_node(0, 1'b1, 7); load_node(1, 1'b1, 7);
    load_node(2, 1'b1, 9); load_node(3, 1'b1, 7);
    start_scan(7'd4, 1'b1, mk(1'b1, 0, 7, 1'b1, 1, 7, 4), e);
    wait_done("ties", e);

    // Inactive nodes with lower EDs are skipped.
    x_cur = {16'd9, 16'd8, 16'd7, 16'd600};
    clear_mem();
    load_node(0, 1'b0, 1); load_node(1, 1'b1, 5); load_node(2, 1'b0, 1);
    start_scan(7'd3, 1'b1, mk(1'b1, 1, 5, 1'b0, 0, 32'hFFFF_FFFF, 3), e);
    wait_done("inactive", e);

    // Empty scan.
    x_cur = {16'd4, 16'd3, 16'd2, 16'd1};
    start_scan(7'd0, 1'b1, mk(1'b0, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 0), e);
    wait_done("n0", e);

    // All slots inactive.
    x_cur = {16'd0, 16'd0, 16'd0, 16'd100};
    clear_mem();
    start_scan(7'd5, 1'b1, mk(1'b0, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 5), e);
    wait_done("all_off", e);

    // Oversized request clamps to MAX_NODES; a start mid-scan is ignored.
    x_cur = {16'd11, 16'd22, 16'd33, 16'd1000};
    for (int i = 0; i < MAX_NODES; i++) load_node(i, 1'b1, 1000 - i);
    load_node(40, 1'b1, 3);
    load_node(41, 1'b1, 3);
    start_scan(7'd100, 1'b1, mk(1'b1, 40, 3, 1'b1, 41, 3, 64), e);
    repeat (20) @(negedge clk);
    start = 1'b1; num_nodes = 7'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("clamp", e);

    // Reset during an N=8 scan aborts without done.
    x_cur = {16'd5, 16'd5, 16'd5, 16'd700};
    for (int i = 0; i < 8; i++) load_node(i, 1'b1, 100 + i);
    start_scan(7'd8, 1'b0, mk(1'b1, 0, 100, 1'b1, 1, 101, 8), e);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Fresh scan after abort completes normally.
    setup_t1();
    start_scan(7'd4, 1'b1, mk(1'b1, 3, 10, 1'b1, 1, 20, 4), e);
    wait_done("post_rst", e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
